cve2_data_access_unit: RTL
==========================

CVE2_DATA_ACCESS_UNIT -- requirements
Module: cve2_data_access_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  rising-edge clock; rst_ni  in  1  asynchronous active-low reset.
REQ-002 SHALL have these core-side inputs:
- lsu_req_i  in  1  start access; sampled in IDLE only
- lsu_we_i  in  1  1=store, 0=load
- lsu_type_i  in  2  00=word, 01=half, 10=byte, 11=reserved (treat as word)
- lsu_sign_ext_i  in  1  sign-extend half/byte loads
- lsu_wdata_i  in  32  store data, LSB-aligned
- adder_result_ex_i  in  32  byte address from the EX-stage ALU adder
REQ-003 SHALL have these bus signals:
- data_req_o  out  1
- data_gnt_i  in  1
- data_rvalid_i  in  1
- data_err_i  in  1
- data_addr_o  out  32  word-aligned address
- data_we_o  out  1
- data_be_o  out  4
- data_wdata_o  out  32
- data_rdata_i  in  32
REQ-004 SHALL have these core-side outputs:
- lsu_rdata_o  out  32
- lsu_resp_valid_o  out  1  one-cycle access-complete pulse
- lsu_busy_o  out  1  state != IDLE
- load_err_o  out  1  one-cycle pulse
- store_err_o  out  1  one-cycle pulse

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID, WAIT_GNT_2, WAIT_RVALID_2.
REQ-006 SHALL, in IDLE with lsu_req_i=1, latch address, type, we, sign_ext and wdata, and assert data_req_o in the same cycle.
- data_gnt_i=1 that cycle: go to WAIT_RVALID.
- otherwise: go to WAIT_GNT.
REQ-007 SHALL hold data_req_o high and keep addr/we/be/wdata stable from request until data_gnt_i=1; WAIT_GNT/WAIT_GNT_2 exit on gnt.
REQ-008 SHALL issue at most one outstanding transaction; data_req_o=0 in WAIT_RVALID/WAIT_RVALID_2.
REQ-009 SHALL classify an access as split when it is a word with addr[1:0]!=0, or a half with addr[1:0]==3; bytes never split.
REQ-010 SHALL drive data_addr_o as follows:
- first beat: {addr[31:2],2'b00}
- second beat: {addr[31:2],2'b00}+4, wrapping modulo 2^32
REQ-011 SHALL drive data_be_o as follows (k=addr[1:0], 4-bit truncation):
- word first beat: 4'b1111<<k; word second beat: 4'b1111>>(4-k)
- half first beat: 4'b0011<<k, except 4'b1000 when k=3; half second beat: 4'b0001
- byte: 4'b0001<<k
REQ-012 SHALL drive data_wdata_o = lsu_wdata_i rotated left by 8*k bits on both beats.
REQ-013 SHALL handle WAIT_RVALID on data_rvalid_i as follows:
- split and no data_err_i: capture data_rdata_i and go to WAIT_GNT_2 with data_req_o asserted the next cycle.
- otherwise: complete and return to IDLE.
REQ-014 SHALL, in WAIT_RVALID_2 on data_rvalid_i, complete and return to IDLE.
REQ-015 SHALL, on completion, pulse lsu_resp_valid_o for one cycle. For loads, lsu_rdata_o SHALL that cycle carry the assembled value:
- bytes from first-beat data (bytes k..3) and second-beat data (bytes 0..k-1), right-aligned
- truncated to the type, then sign- or zero-extended
REQ-016 SHALL hold lsu_rdata_o at its last value outside completion cycles; it reads 0 after reset.
REQ-017 SHALL, when data_err_i=1 with data_rvalid_i, abort any remaining beat and complete in that cycle. That cycle SHALL also:
- pulse load_err_o (if load) or store_err_o (if store)
- pulse lsu_resp_valid_o
REQ-018 SHALL ignore data_rvalid_i and data_err_i in IDLE, WAIT_GNT and WAIT_GNT_2.
REQ-019 SHALL ignore lsu_req_i while lsu_busy_o=1.
REQ-020 SHALL allow a new lsu_req_i in IDLE the cycle after completion; no back-to-back in the completion cycle itself.

Reset
REQ-021 SHALL, on rst_ni low, asynchronously enter IDLE and clear all outputs and internal registers to 0, including mid-access. No pending beat survives reset.
REQ-022 SHALL not pulse any completion or error output in the first cycle after reset release.

Verification
REQ-023 Aligned word load: addr 0x1000, gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF. Required response:
- one beat with data_addr_o=0x1000, data_be_o=1111
- lsu_rdata_o=0xDEADBEEF with resp pulse
REQ-024 Split word store: addr 0x2002, wdata 0x11223344, gnt delayed 2 cycles on each beat. Required response:
- beat1: addr 0x2000, be 1100, wdata 0x33441122
- beat2: addr 0x2004, be 0011, same wdata
- req held stable while waiting for each gnt
REQ-025 Split signed half load: addr 0x3003. Required response:
- beat1: be 1000, rdata 0x80000000
- beat2: be 0001, rdata 0x000000FF
- lsu_rdata_o=0xFFFFFF80
REQ-026 Byte load, zero-extend: addr 0x4001, rdata 0x0000F100 -> lsu_rdata_o=0x000000F1.
REQ-027 Error on beat1 of split word load at 0xFFFFFFFE. Required response:
- load_err_o and lsu_resp_valid_o pulse together
- no second beat is issued to 0x00000000
REQ-028 Reset asserted in WAIT_GNT_2. Required response:
- data_req_o and lsu_busy_o drop immediately
- after release, a new aligned load completes normally

Source files
------------

// File: rtl/cve2_data_access_unit.sv
// Load/store unit bus interface: issues one or two word-aligned bus beats per core access,
// splitting misaligned words/halves, and assembles and extends load data on completion.
module cve2_data_access_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_busy_o,
    output logic        load_err_o,
    output logic        store_err_o
);

    localparam int unsigned DataW = 32;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_GNT      = 3'd1,
        WAIT_RVALID   = 3'd2,
        WAIT_GNT_2    = 3'd3,
        WAIT_RVALID_2 = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DataW-1:0]   addr_q, addr_d;
    logic [1:0]         type_q, type_d;
    logic               we_q, we_d;
    logic               sext_q, sext_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic [DataW-1:0]   rdata1_q, rdata1_d;
    logic [DataW-1:0]   rdata_q, rdata_d;

    logic               req;
    logic               complete;
    logic               second_beat;
    logic [DataW-1:0]   sel_addr;
    logic [1:0]         sel_type;
    logic               sel_we;
    logic [DataW-1:0]   sel_wdata;
    logic [DataW-1:0]   first_data;
    logic [DataW-1:0]   assembled;
    logic [DataW-1:0]   rdata_out;

    function automatic logic is_split(logic [1:0] typ, logic [1:0] k);
        logic s;
        case (typ)
            2'b10:   s = 1'b0;
            2'b01:   s = (k == 2'd3);
            default: s = (k != 2'd0);
        endcase
        return s;
    endfunction

    function automatic logic [3:0] beat_be(logic [1:0] typ, logic [1:0] k, logic second);
        logic [3:0] be;
        case (typ)
            2'b10:   be = 4'b0001 << k;
            2'b01:   be = second ? 4'b0001 : (4'b0011 << k);
            default: be = second ? (4'b1111 >> (3'd4 - {1'b0, k})) : (4'b1111 << k);
        endcase
        return be;
    endfunction

    function automatic logic [31:0] rotl_bytes(logic [31:0] w, logic [1:0] k);
        logic [63:0] dbl;
        dbl = {w, w} << {k, 3'b000};
        return dbl[63:32];
    endfunction

    // Window of bytes k.. across the two beats, then truncate to the access size and extend.
    function automatic logic [31:0] assemble(logic [31:0] d1, logic [31:0] d2, logic [1:0] k,
                                             logic [1:0] typ, logic sext);
        logic [63:0] win;
        logic [31:0] raw;
        logic [31:0] res;
        win = {d2, d1} >> {k, 3'b000};
        raw = win[31:0];
        case (typ)
            2'b10:   res = {{24{sext & raw[7]}}, raw[7:0]};
            2'b01:   res = {{16{sext & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            type_q   <= '0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            we_q     <= we_d;
            sext_q   <= sext_d;
            wdata_q  <= wdata_d;
            rdata1_q <= rdata1_d;
            rdata_q  <= rdata_d;
        end
    end

    // In IDLE the request goes out combinationally from the core inputs; later from the latches.
    assign sel_addr    = (state_q == IDLE) ? adder_result_ex_i : addr_q;
    assign sel_type    = (state_q == IDLE) ? lsu_type_i        : type_q;
    assign sel_we      = (state_q == IDLE) ? lsu_we_i          : we_q;
    assign sel_wdata   = (state_q == IDLE) ? lsu_wdata_i       : wdata_q;
    assign second_beat = (state_q == WAIT_GNT_2);
    assign first_data  = (state_q == WAIT_RVALID_2) ? rdata1_q : data_rdata_i;
    assign assembled   = assemble(first_data, data_rdata_i, addr_q[1:0], type_q, sext_q);

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        type_d           = type_q;
        we_d             = we_q;
        sext_d           = sext_q;
        wdata_d          = wdata_q;
        rdata1_d         = rdata1_q;
        rdata_d          = rdata_q;
        req              = 1'b0;
        complete         = 1'b0;
        lsu_resp_valid_o = 1'b0;
        load_err_o       = 1'b0;
        store_err_o      = 1'b0;
        rdata_out        = rdata_q;

        case (state_q)
            IDLE: begin
                req = lsu_req_i;
                if (lsu_req_i) begin
                    addr_d  = adder_result_ex_i;
                    type_d  = lsu_type_i;
                    we_d    = lsu_we_i;
                    sext_d  = lsu_sign_ext_i;
                    wdata_d = lsu_wdata_i;
                    state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    if (is_split(type_q, addr_q[1:0]) && !data_err_i) begin
                        rdata1_d = data_rdata_i;
                        state_d  = WAIT_GNT_2;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_GNT_2: begin
                req = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID_2;
                end
            end
            WAIT_RVALID_2: begin
                if (data_rvalid_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            lsu_resp_valid_o = 1'b1;
            load_err_o       = data_err_i & ~we_q;
            store_err_o      = data_err_i & we_q;
            if (!data_err_i && !we_q) begin
                rdata_d   = assembled;
                rdata_out = assembled;
            end
        end
    end

    // Bus fields are driven only while a request is up, so they read 0 in reset and when idle.
    assign data_req_o   = req & rst_ni;
    assign data_addr_o  = data_req_o ? ({sel_addr[31:2], 2'b00} + (second_beat ? 32'd4 : 32'd0)) : '0;
    assign data_we_o    = data_req_o & sel_we;
    assign data_be_o    = data_req_o ? beat_be(sel_type, sel_addr[1:0], second_beat) : 4'b0000;
    assign data_wdata_o = data_req_o ? rotl_bytes(sel_wdata, sel_addr[1:0]) : '0;
    assign lsu_rdata_o  = rdata_out;
    assign lsu_busy_o   = (state_q != IDLE);

endmodule
